// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts a plaintext/key pair, performs the initial
// AddRoundKey, then drives the single-round datapath NROUNDS times, feeding
// state and round key back. It returns the ciphertext over a valid/ready
// handshake. Only one block is in flight at a time.
module aes_round_ctrl #(
  parameter int unsigned NROUNDS = 10,
  parameter int unsigned RW      = 4
) (
  input  logic           clock,
  input  logic           reset,
  // plaintext/key input handshake
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_text,
  input  logic [127:0]   in_key,
  // ciphertext output handshake
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_text,
  output logic           busy,
  // round datapath interface
  output logic           rnd_enable,
  output logic [127:0]   rnd_text,
  output logic [127:0]   rnd_key,
  output logic [RW-1:0]  rnd_round,
  input  logic [127:0]   rnd_o_text,
  input  logic [127:0]   rnd_rkey,
  input  logic           rnd_done
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } ctrl_state_t;

  ctrl_state_t    ctrl_q;
  logic [127:0]   state_q;
  logic [127:0]   key_q;
  logic [RW-1:0]  round_q;

  // The datapath always works on the fed-back state and previous round key.
  assign rnd_text  = state_q;
  assign rnd_key   = key_q;
  assign rnd_round = round_q;

  // Sequencer: state, round counter, feedback registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q     <= IDLE;
      state_q    <= '0;
      key_q      <= '0;
      round_q    <= '0;
      out_text   <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      rnd_enable <= 1'b0;
    end else begin
      // The round strobe is a single-cycle pulse unless re-armed below.
      rnd_enable <= 1'b0;
      case (ctrl_q)
        IDLE: begin
          if (in_valid) begin
            // Initial AddRoundKey is folded into the accept.
            state_q    <= in_text ^ in_key;
            key_q      <= in_key;
            round_q    <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            rnd_enable <= 1'b1;
            ctrl_q     <= ISSUE;
          end
        end
        ISSUE: begin
          ctrl_q <= CAPTURE;
        end
        CAPTURE: begin
          if (rnd_done) begin
            state_q <= rnd_o_text;
            if (round_q == LAST_ROUND) begin
              // The datapath's key output after the last round is a dummy;
              // leave key_q untouched.
              out_text  <= rnd_o_text;
              out_valid <= 1'b1;
              ctrl_q    <= DONE;
            end else begin
              key_q      <= rnd_rkey;
              round_q    <= round_q + RW'(1);
              rnd_enable <= 1'b1;
              ctrl_q     <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            // out_text keeps the last ciphertext after the handshake.
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            ctrl_q    <= IDLE;
          end
        end
        default: begin
          ctrl_q <= IDLE;
        end
      endcase
    end
  end

  // Round strobe never fires on two consecutive cycles.
  a_enable_pulse: assert property (@(posedge clock) disable iff (reset)
    rnd_enable |=> !rnd_enable);

  // Ciphertext is stable while the consumer stalls.
  a_out_stable: assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready) |=> $stable(out_text));

  // Round counter stays within the round range.
  a_round_range: assert property (@(posedge clock) disable iff (reset)
    round_q <= LAST_ROUND);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES-128 round datapath.
module tb_aes_round_ctrl;

  localparam int unsigned NR = 10;
  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] LASTR = 4'd9;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_text;
  logic [127:0]  in_key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_text;
  logic          busy;
  logic          rnd_enable;
  logic [127:0]  rnd_text;
  logic [127:0]  rnd_key;
  logic [RW-1:0] rnd_round;
  logic [127:0]  dp_text;
  logic [127:0]  dp_key;
  logic          rnd_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int lat, en_cnt, consec, log_n;
  logic [RW-1:0] rlog [0:63];

  aes_round_ctrl #(.NROUNDS(NR), .RW(RW)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_text    (in_text),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_text   (out_text),
    .busy       (busy),
    .rnd_enable (rnd_enable),
    .rnd_text   (rnd_text),
    .rnd_key    (rnd_key),
    .rnd_round  (rnd_round),
    .rnd_o_text (dp_text),
    .rnd_rkey   (dp_key),
    .rnd_done   (rnd_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- AES-128 reference round ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] q;
    logic [7:0] s;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    s = 8'h63 ^ r;
    q = r;
    for (int i = 0; i < 4; i++) begin
      q = {q[6:0], q[7]};
      s = s ^ q;
    end
    return s;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [127:0] n;
    rc = 8'h01;
    for (int i = 0; i < r; i++) rc = xt(rc);
    t = {sbox(k[103:96]), sbox(k[127:120]), sbox(k[119:112]), sbox(k[111:104]) ^ rc};
    n[31:0]   = k[31:0]   ^ t;
    n[63:32]  = k[63:32]  ^ n[31:0];
    n[95:64]  = k[95:64]  ^ n[63:32];
    n[127:96] = k[127:96] ^ n[95:64];
    return n;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (last) begin
        o[32*c +: 32] = {a3, a2, a1, a0};
      end else begin
        o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return o ^ rk;
  endfunction

  // Registered round datapath; key output is forced to a constant after the last round.
  always @(posedge clock) begin
    if (reset) begin
      dp_text <= '0;
      dp_key  <= '0;
    end else if (rnd_enable) begin
      dp_text <= aes_round(rnd_text, next_key(rnd_key, int'(rnd_round)), rnd_round == LASTR);
      dp_key  <= (rnd_round == LASTR) ? 128'h0 : next_key(rnd_key, int'(rnd_round));
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with in_ready expected; returns at the negedge after the accept edge.
  task automatic start_block(input logic [127:0] t, input logic [127:0] k);
    in_text  = t;
    in_key   = k;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_text  = ~t;
    in_key   = ~k;
  endtask

  // Runs from the negedge after the accept edge until out_valid (bounded),
  // logging strobes and round indices; optionally stalls rnd_done for 3 cycles.
  task automatic collect(input int stall_round);
    int   stall_left;
    logic prev_en;
    stall_left = 0;
    prev_en    = 1'b0;
    lat = 0; en_cnt = 0; consec = 0; log_n = 0;
    while (!out_valid && lat < 100) begin
      if (rnd_enable) begin
        en_cnt++;
        if (prev_en) consec++;
      end
      prev_en = rnd_enable;
      if (log_n < 64) begin
        rlog[log_n] = rnd_round;
        log_n++;
      end
      if (stall_left > 0 && !rnd_enable) begin
        rnd_done = 1'b0;
        stall_left--;
      end else begin
        rnd_done = 1'b1;
      end
      if (rnd_enable && int'(rnd_round) == stall_round) stall_left = 3;
      @(negedge clock);
      lat++;
    end
    rnd_done = 1'b1;
  endtask

  typedef struct packed {
    logic [127:0] text;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] C1_T = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_K = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_C = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] AB_T = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] AB_K = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] AB_C = 128'h320b6a19978511dcfb09dc021d842539;

  vec_t vecs [3];

  initial begin
    int g;
    int bad;
    int t0;
    int t1;

    vecs[0] = '{text: C1_T, key: C1_K, exp: C1_C};
    vecs[1] = '{text: AB_T, key: AB_K, exp: AB_C};
    vecs[2] = '{text: 128'h0, key: 128'h0, exp: 128'h2e2b34ca59fa4c883b2c8aefd44be966};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rnd_done = 1'b1;
    in_text = '0; in_key = '0;
    repeat (3) @(negedge clock);

    // Reset state
    check_b("rst_in_ready", in_ready, 1'b1);
    check_b("rst_out_valid", out_valid, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_rnd_enable", rnd_enable, 1'b0);
    check_w("rst_out_text", out_text, 128'h0);
    check_w("rst_rnd_text", rnd_text, 128'h0);
    check_w("rst_rnd_key", rnd_key, 128'h0);
    check_i("rst_rnd_round", int'(rnd_round), 0);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven known-answer blocks with out_ready held high
    for (int i = 0; i < 3; i++) begin
      check_b($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
      start_block(vecs[i].text, vecs[i].key);
      check_b($sformatf("v%0d_busy", i), busy, 1'b1);
      check_w($sformatf("v%0d_first_state", i), rnd_text, vecs[i].text ^ vecs[i].key);
      collect(-1);
      check_i($sformatf("v%0d_latency", i), lat, 20);
      check_w($sformatf("v%0d_out_text", i), out_text, vecs[i].exp);
      check_i($sformatf("v%0d_enables", i), en_cnt, 10);
      check_i($sformatf("v%0d_consec_en", i), consec, 0);
      bad = 0;
      for (int j = 0; j < log_n; j++) if (int'(rlog[j]) != j / 2) bad++;
      check_i($sformatf("v%0d_round_len", i), log_n, 20);
      check_i($sformatf("v%0d_round_seq_bad", i), bad, 0);
      @(negedge clock);
      check_b($sformatf("v%0d_valid_drop", i), out_valid, 1'b0);
      check_b($sformatf("v%0d_busy_drop", i), busy, 1'b0);
      check_b($sformatf("v%0d_ready_back", i), in_ready, 1'b1);
      check_w($sformatf("v%0d_text_hold", i), out_text, vecs[i].exp);
    end

    // Backpressure: 7 cycles of out_ready low while a new pair waits
    out_ready = 1'b0;
    start_block(C1_T, C1_K);
    collect(-1);
    check_i("bp_latency", lat, 20);
    in_valid = 1'b1; in_text = AB_T; in_key = AB_K;
    for (int k = 0; k < 7; k++) begin
      check_b($sformatf("bp_valid_%0d", k), out_valid, 1'b1);
      check_w($sformatf("bp_text_%0d", k), out_text, C1_C);
      check_b($sformatf("bp_in_ready_%0d", k), in_ready, 1'b0);
      @(negedge clock);
    end
    check_b("bp_valid_last", out_valid, 1'b1);
    check_w("bp_text_last", out_text, C1_C);
    out_ready = 1'b1;
    @(negedge clock);
    check_b("bp_idle_ready", in_ready, 1'b1);
    check_b("bp_idle_busy", busy, 1'b0);
    check_b("bp_idle_valid", out_valid, 1'b0);
    @(negedge clock);
    check_b("bp_second_accept", busy, 1'b1);
    in_valid = 1'b0; in_text = '1; in_key = '1;
    collect(-1);
    check_i("bp2_latency", lat, 20);
    check_w("bp2_out_text", out_text, AB_C);
    @(negedge clock);

    // Datapath stall of 3 cycles in round 4
    start_block(C1_T, C1_K);
    collect(4);
    check_i("stall_latency", lat, 23);
    check_i("stall_enables", en_cnt, 10);
    check_w("stall_out_text", out_text, C1_C);
    @(negedge clock);

    // Reset in the middle of round 5
    start_block(AB_T, AB_K);
    g = 0;
    while (int'(rnd_round) != 5 && g < 40) begin
      @(negedge clock);
      g++;
    end
    check_i("mid_reset_round", int'(rnd_round), 5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_b("mr_out_valid", out_valid, 1'b0);
    check_b("mr_rnd_enable", rnd_enable, 1'b0);
    check_b("mr_in_ready", in_ready, 1'b1);
    check_b("mr_busy", busy, 1'b0);
    check_i("mr_round", int'(rnd_round), 0);
    check_w("mr_out_text", out_text, 128'h0);
    @(negedge clock);
    start_block(C1_T, C1_K);
    collect(-1);
    check_i("mr_c1_latency", lat, 20);
    check_w("mr_c1_out_text", out_text, C1_C);
    @(negedge clock);

    // Back-to-back with in_valid and out_ready held high
    in_valid = 1'b1; in_text = C1_T; in_key = C1_K;
    @(negedge clock);
    t0 = cyc;
    check_b("b2b_first_busy", busy, 1'b1);
    in_text = AB_T; in_key = AB_K;
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clock);
      g++;
    end
    check_w("b2b_first_text", out_text, C1_C);
    g = 0;
    while (busy && g < 10) begin
      @(negedge clock);
      g++;
    end
    g = 0;
    while (!busy && g < 10) begin
      @(negedge clock);
      g++;
    end
    t1 = cyc;
    check_i("b2b_accept_gap", t1 - t0, 22);
    in_valid = 1'b0;
    collect(-1);
    check_i("b2b_second_latency", lat, 20);
    check_w("b2b_second_text", out_text, AB_C);
    @(negedge clock);
    check_b("b2b_end_idle", in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
